// File: rtl/seq_detect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_ctrl_pkg
// Brief    : Shared FSM encodings and width helpers for the detector sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package seq_detect_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLR   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DEFAULT_WORD_W = 8;

    // Width needed to hold a match count in the range 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer
// Brief    : Parallel-load, MSB-first shift register with a bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module bit_serializer
    import seq_detect_ctrl_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              sout,
    output logic              last
);

    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] r_shreg;
    logic [BC_W-1:0]   r_bitcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else if (load) begin
            r_shreg  <= din;
            r_bitcnt <= '0;
        end else if (shift) begin
            r_shreg  <= {r_shreg[WORD_W-2:0], 1'b0};
            r_bitcnt <= r_bitcnt + BC_W'(1);
        end
    end

    assign sout = r_shreg[WORD_W-1];
    assign last = (r_bitcnt == BC_W'(WORD_W - 1));

endmodule
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_ctrl
// Brief    : Feeds words MSB-first into a serial Mealy detector and returns
//            the number of cycles the detector flagged a match.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter int  WORD_W        = DEFAULT_WORD_W,
    parameter bit  CLEAR_BETWEEN = 1'b1,
    localparam int CNT_W         = cnt_width(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              det_x,
    output logic              det_rst,
    input  logic              det_y,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_hit,
    input  logic              out_ready,
    output logic              busy
);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] r_match;
    logic             w_accept;
    logic             w_shift;
    logic             w_sout;
    logic             w_last;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_shift  = (r_state == ST_SHIFT);

    bit_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .shift (w_shift),
        .din   (in_data),
        .sout  (w_sout),
        .last  (w_last)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = CLEAR_BETWEEN ? ST_CLR : ST_SHIFT;
            ST_CLR:   w_next = ST_SHIFT;
            ST_SHIFT: if (w_last) w_next = ST_DONE;
            ST_DONE:  if (out_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Count can never exceed WORD_W, so CNT_W bits always suffice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_match <= '0;
        end else if (w_accept) begin
            r_match <= '0;
        end else if (w_shift && det_y) begin
            r_match <= r_match + CNT_W'(1);
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_count = r_match;
    assign out_hit   = (r_match != '0);
    assign det_x     = w_shift && w_sout;
    // Detector is held in reset whenever this block is, not only in CLR.
    assign det_rst   = !rst || (r_state == ST_CLR);

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_ctrl
// Brief    : Directed self-checking bench with a "11" Mealy detector stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          a_in_valid, a_in_ready, a_det_x, a_det_rst, a_det_y;
    logic          a_out_valid, a_out_hit, a_out_ready, a_busy;
    logic [W-1:0]  a_in_data;
    logic [CW-1:0] a_out_count;

    logic          b_in_valid, b_in_ready, b_det_x, b_det_rst, b_det_y;
    logic          b_out_valid, b_out_hit, b_out_ready, b_busy;
    logic [W-1:0]  b_in_data;
    logic [CW-1:0] b_out_count;

    seq_detect_ctrl #(.WORD_W(W), .CLEAR_BETWEEN(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .det_x(a_det_x), .det_rst(a_det_rst),
        .det_y(a_det_y), .out_valid(a_out_valid), .out_count(a_out_count),
        .out_hit(a_out_hit), .out_ready(a_out_ready), .busy(a_busy)
    );

    seq_detect_ctrl #(.WORD_W(W), .CLEAR_BETWEEN(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .det_x(b_det_x), .det_rst(b_det_rst),
        .det_y(b_det_y), .out_valid(b_out_valid), .out_count(b_out_count),
        .out_hit(b_out_hit), .out_ready(b_out_ready), .busy(b_busy)
    );

    // "11" detector stubs: y = x & prev_x, prev cleared by det_rst.
    logic a_prev, b_prev;
    always_ff @(posedge clk) a_prev <= a_det_rst ? 1'b0 : a_det_x;
    always_ff @(posedge clk) b_prev <= b_det_rst ? 1'b0 : b_det_x;
    assign a_det_y = a_det_x & a_prev;
    assign b_det_y = b_det_x & b_prev;

    int b_rst_pulses = 0;
    always_ff @(posedge clk) if (rst && b_det_rst) b_rst_pulses <= b_rst_pulses + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int pairs11(input logic [W-1:0] w);
        int c = 0;
        for (int i = 0; i < W - 1; i++) if (w[i] && w[i+1]) c++;
        return c;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sends one word on DUT A with out_ready assumed high; latency counts
    // cycles from the handshake cycle to the first cycle with out_valid=1.
    task automatic send_a(input logic [W-1:0] d, output int lat,
                          output logic [CW-1:0] cnt, output logic hit, output logic ok);
        ok = 1'b1;
        a_in_data  = d;
        a_in_valid = 1'b1;
        for (int i = 0; i < 30 && !a_in_ready; i++) tick;
        if (!a_in_ready) ok = 1'b0;
        tick;
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 40) begin
            tick;
            lat++;
        end
        if (!a_out_valid) ok = 1'b0;
        cnt = a_out_count;
        hit = a_out_hit;
        tick;
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (a_det_rst !== 1'b1) begin n_fail++; $display("FAIL reset_det_rst: got %b need 1", a_det_rst); end
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b need 0", a_out_valid); end
        n_checks++; if (a_out_count !== 4'd0) begin n_fail++; $display("FAIL reset_out_count: got %0d need 0", a_out_count); end
        n_checks++; if (a_busy !== 1'b0 || a_det_x !== 1'b0 || a_out_hit !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_x_hit: got %b%b%b need 000", a_busy, a_det_x, a_out_hit); end
        tick; tick;
        rst = 1'b1;
        tick;
        n_checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b%b need 11", a_in_ready, b_in_ready); end
        n_checks++; if (a_det_rst !== 1'b0) begin n_fail++; $display("FAIL reset_release_det_rst: got %b need 0", a_det_rst); end
    endtask

    task automatic test_basic;
        int lat; logic [CW-1:0] cnt; logic hit, ok;
        a_out_ready = 1'b1;
        send_a(8'b0110_1110, lat, cnt, hit, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_timeout: got %b need 1", ok); end
        n_checks++; if (cnt !== 4'd3) begin n_fail++; $display("FAIL basic_count: got %0d need 3", cnt); end
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL basic_hit: got %b need 1", hit); end
        n_checks++; if (lat != 10) begin n_fail++; $display("FAIL basic_latency: got %0d need 10", lat); end
    endtask

    task automatic test_patterns;
        int lat; logic [CW-1:0] cnt; logic hit, ok;
        send_a(8'h00, lat, cnt, hit, ok);
        n_checks++; if (!ok || cnt !== 4'd0 || hit !== 1'b0) begin
            n_fail++; $display("FAIL zeros: got count %0d hit %b ok %b need 0 0 1", cnt, hit, ok); end
        send_a(8'hFF, lat, cnt, hit, ok);
        n_checks++; if (!ok || cnt !== 4'd7 || hit !== 1'b1) begin
            n_fail++; $display("FAIL ones: got count %0d hit %b ok %b need 7 1 1", cnt, hit, ok); end
    endtask

    task automatic test_backpressure;
        int w;
        a_out_ready = 1'b0;
        a_in_data   = 8'b1011_0110;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 30 && !a_in_ready; i++) tick;
        tick;
        a_in_valid = 1'b0;
        w = 0;
        while (!a_out_valid && w < 40) begin tick; w++; end
        n_checks++; if (a_out_count !== 4'd2 || a_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_first_count: got %0d valid %b need 2 1", a_out_count, a_out_valid); end
        a_in_data  = 8'b0110_1110;
        a_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (a_out_valid !== 1'b1 || a_out_count !== 4'd2 || a_in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d: got valid %b count %0d in_ready %b need 1 2 0",
                                   i, a_out_valid, a_out_count, a_in_ready); end
            tick;
        end
        a_out_ready = 1'b1;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_release_ready: got %b need 0", a_in_ready); end
        tick;
        n_checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_idle: got in_ready %b out_valid %b need 1 0", a_in_ready, a_out_valid); end
        tick;
        a_in_valid = 1'b0;
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL bp_second_accept: got busy %b need 1", a_busy); end
        w = 0;
        while (!a_out_valid && w < 40) begin tick; w++; end
        n_checks++; if (a_out_count !== 4'd3 || a_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_second_count: got %0d valid %b need 3 1", a_out_count, a_out_valid); end
        tick;
    endtask

    task automatic test_reset_mid;
        int lat; logic [CW-1:0] cnt; logic hit, ok;
        a_in_data  = 8'b0110_1110;
        a_in_valid = 1'b1;
        for (int i = 0; i < 30 && !a_in_ready; i++) tick;
        tick;
        a_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b need 1", a_busy); end
        rst = 1'b0;
        #1;
        n_checks++; if (a_det_rst !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_state: got det_rst %b out_valid %b busy %b need 1 0 0",
                               a_det_rst, a_out_valid, a_busy); end
        tick; tick;
        rst = 1'b1;
        tick;
        n_checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_release: got in_ready %b out_valid %b need 1 0", a_in_ready, a_out_valid); end
        send_a(8'b0110_1110, lat, cnt, hit, ok);
        n_checks++; if (!ok || cnt !== 4'd3) begin
            n_fail++; $display("FAIL mid_next_word: got count %0d ok %b need 3 1", cnt, ok); end
    endtask

    task automatic test_no_clear;
        int w;
        b_out_ready = 1'b1;
        b_in_data   = 8'h01;
        b_in_valid  = 1'b1;
        for (int i = 0; i < 30 && !b_in_ready; i++) tick;
        tick;
        b_in_data = 8'h80;
        w = 1;
        while (!b_out_valid && w < 40) begin tick; w++; end
        n_checks++; if (w != 9) begin n_fail++; $display("FAIL noclr_latency: got %0d need 9", w); end
        n_checks++; if (b_out_count !== 4'd0 || b_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL noclr_first: got %0d valid %b need 0 1", b_out_count, b_out_valid); end
        tick;
        n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL noclr_ready: got %b need 1", b_in_ready); end
        tick;
        b_in_valid = 1'b0;
        w = 0;
        while (!b_out_valid && w < 40) begin tick; w++; end
        n_checks++; if (b_out_count !== 4'd0 || b_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL noclr_second: got %0d valid %b need 0 1", b_out_count, b_out_valid); end
        tick;
        n_checks++; if (b_rst_pulses != 0) begin n_fail++; $display("FAIL noclr_det_rst: got %0d pulses need 0", b_rst_pulses); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] words [4];
        int acc [4];
        int na, nr, cyc;
        logic hs;
        for (int i = 0; i < 4; i++) words[i] = W'($urandom);
        na = 0; nr = 0; cyc = 0;
        a_out_ready = 1'b1;
        a_in_data   = words[0];
        a_in_valid  = 1'b1;
        while (nr < 4 && cyc < 200) begin
            if (a_out_valid) begin
                n_checks++; if (a_out_count !== CW'(pairs11(words[nr])) || a_out_hit !== (pairs11(words[nr]) != 0)) begin
                    n_fail++; $display("FAIL b2b_count%0d: word %h got %0d hit %b need %0d", nr, words[nr],
                                       a_out_count, a_out_hit, pairs11(words[nr])); end
                nr++;
            end
            hs = a_in_valid && a_in_ready;
            if (hs) begin acc[na] = cyc; na++; end
            tick;
            cyc++;
            if (hs) begin
                if (na < 4) a_in_data = words[na];
                else        a_in_valid = 1'b0;
            end
        end
        a_in_valid = 1'b0;
        n_checks++; if (nr != 4 || na != 4) begin n_fail++; $display("FAIL b2b_results: got %0d/%0d need 4/4", na, nr); end
        for (int i = 1; i < na; i++) begin
            n_checks++; if (acc[i] - acc[i-1] != 11) begin
                n_fail++; $display("FAIL b2b_spacing%0d: got %0d need 11", i, acc[i] - acc[i-1]); end
        end
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        test_reset;
        test_basic;
        test_patterns;
        test_backpressure;
        test_reset_mid;
        test_no_clear;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
